// File: rtl/control_pkg.sv
// Shared types and encodings for the multi-cycle control unit: FSM states,
// opcodes, C-type function bit positions and datapath select codes.
package control_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        JUMP      = 4'd6,
        BRANCH    = 4'd7,
        ALU_EXEC  = 4'd8,
        ALU_WB    = 4'd9
    } state_t;

    // Opcodes (instruction bits [15:12])
    localparam logic [3:0] OP_LOAD    = 4'b0000;
    localparam logic [3:0] OP_STORE   = 4'b0001;
    localparam logic [3:0] OP_JUMP    = 4'b0010;
    localparam logic [3:0] OP_BRANCHZ = 4'b0100;
    localparam logic [3:0] OP_CTYPE   = 4'b1000;
    localparam logic [3:0] OP_ADDI    = 4'b1100;
    localparam logic [3:0] OP_SUBI    = 4'b1101;
    localparam logic [3:0] OP_ANDI    = 4'b1110;
    localparam logic [3:0] OP_ORI     = 4'b1111;

    // C-type function field bit positions (one-hot)
    localparam int FN_MOVETO   = 0;
    localparam int FN_MOVEFROM = 1;
    localparam int FN_ADD      = 2;
    localparam int FN_SUB      = 3;
    localparam int FN_AND      = 4;
    localparam int FN_OR       = 5;
    localparam int FN_NOT      = 6;
    localparam int FN_NOP      = 7;

    // ALUControl codes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_NOTB  = 3'b100;
    localparam logic [2:0] ALU_PASSA = 3'b101;
    localparam logic [2:0] ALU_PASSB = 3'b110;

    // ALU operand selects
    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_A     = 2'd2;
    localparam logic [1:0] SRCB_B     = 2'd0;
    localparam logic [1:0] SRCB_ONE   = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;

    // Immediate extension and PC source selects
    localparam logic [1:0] IMM_ZERO     = 2'd0;
    localparam logic [1:0] IMM_SIGN     = 2'd1;
    localparam logic [1:0] PCSRC_NEXT   = 2'd0;
    localparam logic [1:0] PCSRC_JUMP   = 2'd1;
    localparam logic [1:0] PCSRC_BRANCH = 2'd2;

    // True when the function field names exactly one executable C-type op:
    // a single set bit, and that bit lies in [6:0]. NOP (bit 7), an empty
    // field and any multi-hot pattern all count as "nothing to execute".
    function automatic logic func_is_onehot7(input logic [8:0] func);
        logic [3:0] ones;
        ones = 4'd0;
        for (int i = 0; i < 7; i++) begin
            ones = ones + {3'b000, func[i]};
        end
        return (ones == 4'd1) && (func[8:7] == 2'b00);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps opcode and C-type function field to the
// ALU operation, operand selects, immediate extension and MoveTo flag.
module alu_decoder
    import control_pkg::*;
(
    input  logic [3:0] Op,
    input  logic [8:0] Func,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUSrcA,
    output logic       MoveTo
);

    // Decode ALU controls; unrecognised combinations leave everything at zero
    always_comb begin
        ALUControl = ALU_ADD;
        ImmSrc     = IMM_ZERO;
        ALUSrcB    = SRCB_B;
        ALUSrcA    = SRCA_PC;
        MoveTo     = 1'b0;
        case (Op)
            OP_CTYPE: begin
                if (func_is_onehot7(Func)) begin
                    case (1'b1)
                        Func[FN_MOVETO]: begin
                            ALUSrcA    = SRCA_A;
                            ALUControl = ALU_PASSA;
                            MoveTo     = 1'b1;
                        end
                        Func[FN_MOVEFROM]: begin
                            ALUControl = ALU_PASSB;
                        end
                        Func[FN_ADD]: begin
                            ALUSrcA    = SRCA_A;
                            ALUControl = ALU_ADD;
                        end
                        Func[FN_SUB]: begin
                            ALUSrcA    = SRCA_A;
                            ALUControl = ALU_SUB;
                        end
                        Func[FN_AND]: begin
                            ALUSrcA    = SRCA_A;
                            ALUControl = ALU_AND;
                        end
                        Func[FN_OR]: begin
                            ALUSrcA    = SRCA_A;
                            ALUControl = ALU_OR;
                        end
                        Func[FN_NOT]: begin
                            ALUControl = ALU_NOTB;
                        end
                        default: begin
                            ALUControl = ALU_ADD;
                        end
                    endcase
                end else begin
                    ALUControl = ALU_ADD;
                end
            end
            OP_ADDI: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_SIGN;
                ALUControl = ALU_ADD;
            end
            OP_SUBI: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_SIGN;
                ALUControl = ALU_SUB;
            end
            OP_ANDI: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_ZERO;
                ALUControl = ALU_AND;
            end
            OP_ORI: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_ZERO;
                ALUControl = ALU_OR;
            end
            default: begin
                ALUControl = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: Moore FSM sequencing fetch, decode, memory,
// jump, branch and ALU instructions. PCWrite in BRANCH follows Zero.
// While reset is high every write enable is forced low.
module control_unit
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Op,
    input  logic [8:0] Func,
    input  logic       Zero,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       A3Src,
    output logic       PCWrite,
    output logic       OldPCWrite,
    output logic       MDRWrite,
    output logic       ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal
);

    state_t     state_r;
    state_t     state_next_s;

    logic [2:0] dec_aluctrl_s;
    logic [1:0] dec_immsrc_s;
    logic [1:0] dec_alusrcb_s;
    logic [1:0] dec_alusrca_s;
    logic       dec_moveto_s;

    // Decoded ALU controls latched on leaving DECODE so ALU_EXEC and ALU_WB
    // see values that cannot move even if Op/Func wobble.
    logic [2:0] ex_aluctrl_r;
    logic [1:0] ex_immsrc_r;
    logic [1:0] ex_alusrcb_r;
    logic [1:0] ex_alusrca_r;
    logic       move_to_r;
    logic       is_store_r;

    logic       adrsrc_s, memwrite_s, irwrite_s, regwrite_s, a3src_s;
    logic       pcwrite_s, oldpcwrite_s, mdrwrite_s, resultsrc_s, illegal_s;
    logic [1:0] alusrca_s, alusrcb_s, immsrc_s, pcsrc_s;
    logic [2:0] aluctrl_s;

    alu_decoder u_alu_decoder (
        .Op         (Op),
        .Func       (Func),
        .ALUControl (dec_aluctrl_s),
        .ImmSrc     (dec_immsrc_s),
        .ALUSrcB    (dec_alusrcb_s),
        .ALUSrcA    (dec_alusrca_s),
        .MoveTo     (dec_moveto_s)
    );

    // State register; reset returns to FETCH without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Capture instruction-dependent controls while in DECODE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_aluctrl_r <= ALU_ADD;
            ex_immsrc_r  <= IMM_ZERO;
            ex_alusrcb_r <= SRCB_B;
            ex_alusrca_r <= SRCA_PC;
            move_to_r    <= 1'b0;
            is_store_r   <= 1'b0;
        end else if (state_r == DECODE) begin
            ex_aluctrl_r <= dec_aluctrl_s;
            ex_immsrc_r  <= dec_immsrc_s;
            ex_alusrcb_r <= dec_alusrcb_s;
            ex_alusrca_r <= dec_alusrca_s;
            move_to_r    <= dec_moveto_s;
            is_store_r   <= (Op == OP_STORE);
        end else begin
            ex_aluctrl_r <= ex_aluctrl_r;
            ex_immsrc_r  <= ex_immsrc_r;
            ex_alusrcb_r <= ex_alusrcb_r;
            ex_alusrca_r <= ex_alusrca_r;
            move_to_r    <= move_to_r;
            is_store_r   <= is_store_r;
        end
    end

    // Next-state and per-state output decode; unlisted outputs stay zero
    always_comb begin
        state_next_s = FETCH;
        adrsrc_s     = 1'b0;
        memwrite_s   = 1'b0;
        irwrite_s    = 1'b0;
        regwrite_s   = 1'b0;
        a3src_s      = 1'b0;
        pcwrite_s    = 1'b0;
        oldpcwrite_s = 1'b0;
        mdrwrite_s   = 1'b0;
        resultsrc_s  = 1'b0;
        illegal_s    = 1'b0;
        alusrca_s    = SRCA_PC;
        alusrcb_s    = SRCB_B;
        immsrc_s     = IMM_ZERO;
        pcsrc_s      = PCSRC_NEXT;
        aluctrl_s    = ALU_ADD;
        case (state_r)
            FETCH: begin
                irwrite_s    = 1'b1;
                oldpcwrite_s = 1'b1;
                pcwrite_s    = 1'b1;
                alusrcb_s    = SRCB_ONE;
                state_next_s = DECODE;
            end
            DECODE: begin
                case (Op)
                    OP_LOAD, OP_STORE: state_next_s = MEM_ADDR;
                    OP_JUMP:           state_next_s = JUMP;
                    OP_BRANCHZ:        state_next_s = BRANCH;
                    OP_CTYPE: begin
                        if (func_is_onehot7(Func)) begin
                            state_next_s = ALU_EXEC;
                        end else begin
                            state_next_s = FETCH;
                        end
                    end
                    OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: state_next_s = ALU_EXEC;
                    default: begin
                        state_next_s = FETCH;
                        illegal_s    = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                alusrcb_s    = SRCB_IMM;
                immsrc_s     = IMM_ZERO;
                aluctrl_s    = ALU_PASSB;
                state_next_s = is_store_r ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                adrsrc_s     = 1'b1;
                mdrwrite_s   = 1'b1;
                state_next_s = MEM_WB;
            end
            MEM_WB: begin
                regwrite_s   = 1'b1;
                resultsrc_s  = 1'b1;
                state_next_s = FETCH;
            end
            MEM_WRITE: begin
                adrsrc_s     = 1'b1;
                memwrite_s   = 1'b1;
                state_next_s = FETCH;
            end
            JUMP: begin
                pcsrc_s      = PCSRC_JUMP;
                pcwrite_s    = 1'b1;
                state_next_s = FETCH;
            end
            BRANCH: begin
                alusrca_s    = SRCA_A;
                aluctrl_s    = ALU_PASSA;
                pcsrc_s      = PCSRC_BRANCH;
                pcwrite_s    = Zero;
                state_next_s = FETCH;
            end
            ALU_EXEC: begin
                aluctrl_s    = ex_aluctrl_r;
                immsrc_s     = ex_immsrc_r;
                alusrcb_s    = ex_alusrcb_r;
                alusrca_s    = ex_alusrca_r;
                state_next_s = ALU_WB;
            end
            ALU_WB: begin
                regwrite_s   = 1'b1;
                a3src_s      = move_to_r;
                state_next_s = FETCH;
            end
            default: begin
                state_next_s = FETCH;
            end
        endcase
    end

    // Write enables are suppressed for as long as reset is held
    assign PCWrite    = pcwrite_s    & ~reset;
    assign IRWrite    = irwrite_s    & ~reset;
    assign RegWrite   = regwrite_s   & ~reset;
    assign MemWrite   = memwrite_s   & ~reset;
    assign OldPCWrite = oldpcwrite_s & ~reset;
    assign MDRWrite   = mdrwrite_s   & ~reset;
    assign Illegal    = illegal_s    & ~reset;

    assign AdrSrc     = adrsrc_s;
    assign A3Src      = a3src_s;
    assign ResultSrc  = resultsrc_s;
    assign ALUSrcA    = alusrca_s;
    assign ALUSrcB    = alusrcb_s;
    assign ImmSrc     = immsrc_s;
    assign PCSrc      = pcsrc_s;
    assign ALUControl = aluctrl_s;

endmodule
